// File: rtl/dom_conv_mc.sv
// Multi-channel domain converter: tagged beats are buffered in per-slot FIFOs and
// re-serialised onto one registered valid/ready output with burst-atomic arbitration.
module dom_conv_mc #(
   parameter int NUM_CH     = 4,
   parameter int SSI_WIDTH  = 2,
   parameter int SAM_OFFSET = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int MODE       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   output logic                  ready_i,
   input  logic [SSI_WIDTH-1:0]  SSI_i,
   input  logic [SAM_OFFSET-1:0] s_i,
   input  logic                  wt_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   input  logic                  ready_o,
   output logic [SSI_WIDTH-1:0]  SSI_o,
   output logic [SAM_OFFSET-1:0] s_o,
   output logic                  wt_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [NUM_CH-1:0]     FDSTI_o_all,
   output logic [NUM_CH-1:0]     FDSSI_o,
   output logic [7:0]            err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int FW = 1 + SAM_OFFSET + DATA_WIDTH;

   typedef enum logic {ST_UNLOCKED, ST_LOCKED} arbState_t;

   logic [FW-1:0]     r_mem  [NUM_CH][DEPTH];
   logic [AW:0]       r_wptr [NUM_CH];
   logic [AW:0]       r_rptr [NUM_CH];

   arbState_t         r_state;
   arbState_t         w_stateNext;
   logic [CW-1:0]     r_lockCh;
   logic [CW-1:0]     w_lockChNext;
   logic [CW-1:0]     r_rrPtr;
   logic [CW-1:0]     w_rrPtrNext;

   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_nonEmpty;
   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;
   logic              w_inRange;
   logic              w_drop;
   logic              w_grantValid;
   logic [CW-1:0]     w_grantCh;
   logic [FW-1:0]     w_head;
   logic              w_load;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   always_comb begin
      w_full     = '0;
      w_nonEmpty = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_full[c]     = (r_wptr[c][AW] != r_rptr[c][AW]) &&
                         (r_wptr[c][AW-1:0] == r_rptr[c][AW-1:0]);
         w_nonEmpty[c] = (r_wptr[c] != r_rptr[c]);
      end
   end

   assign FDSTI_o_all = w_full;
   assign FDSSI_o     = w_nonEmpty;

   // Out-of-range slot indices are always accepted so the upstream never stalls on them.
   always_comb begin
      w_inRange = 1'b0;
      ready_i   = 1'b1;
      w_push    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (SSI_i == SSI_WIDTH'(c)) begin
            w_inRange = 1'b1;
            ready_i   = !w_full[c];
            w_push[c] = valid_i && !w_full[c];
         end
      end
      w_drop = valid_i && !w_inRange;
   end

   always_comb begin
      int            idx;
      logic [CW-1:0] scanCh;
      idx          = 0;
      scanCh       = '0;
      w_grantValid = 1'b0;
      w_grantCh    = '0;
      if (r_state == ST_LOCKED) begin
         w_grantCh    = r_lockCh;
         w_grantValid = w_nonEmpty[r_lockCh];
      end else if (MODE == 1) begin
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_nonEmpty[c]) begin
               w_grantValid = 1'b1;
               w_grantCh    = CW'(c);
            end
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(r_rrPtr) + k;
            if (idx >= NUM_CH) begin
               idx = idx - NUM_CH;
            end
            scanCh = CW'(idx);
            if (!w_grantValid && w_nonEmpty[scanCh]) begin
               w_grantValid = 1'b1;
               w_grantCh    = scanCh;
            end
         end
      end
   end

   assign w_head = r_mem[w_grantCh][r_rptr[w_grantCh][AW-1:0]];
   assign w_load = (!valid_o || ready_o) && w_grantValid;

   always_comb begin
      w_pop = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_pop[c] = w_load && (w_grantCh == CW'(c));
      end
   end

   // A beat without the write-through flag pins the arbiter to its channel until the burst ends.
   always_comb begin
      w_stateNext  = r_state;
      w_lockChNext = r_lockCh;
      w_rrPtrNext  = r_rrPtr;
      if (w_load) begin
         if (!w_head[FW-1]) begin
            w_stateNext  = ST_LOCKED;
            w_lockChNext = w_grantCh;
         end else begin
            w_stateNext = ST_UNLOCKED;
            if (MODE == 0) begin
               w_rrPtrNext = (w_grantCh == CW'(NUM_CH - 1)) ? '0 : w_grantCh + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_UNLOCKED;
         r_lockCh <= '0;
         r_rrPtr  <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_lockCh <= w_lockChNext;
         r_rrPtr  <= w_rrPtrNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_push[c]) begin
               r_wptr[c] <= r_wptr[c] + 1'b1;
            end
            if (w_pop[c]) begin
               r_rptr[c] <= r_rptr[c] + 1'b1;
            end
         end
      end
   end

   // Storage is left unreset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_push[c]) begin
            r_mem[c][r_wptr[c][AW-1:0]] <= {wt_i, s_i, data_i};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o <= 1'b0;
         SSI_o   <= '0;
         s_o     <= '0;
         wt_o    <= 1'b0;
         data_o  <= '0;
      end else if (w_load) begin
         valid_o              <= 1'b1;
         SSI_o                <= SSI_WIDTH'(w_grantCh);
         {wt_o, s_o, data_o}  <= w_head;
      end else if (ready_o) begin
         valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (w_drop && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dom_conv_mc.sv
// Directed bench for dom_conv_mc: a vector table for basic flow, then hand-written
// sequences for backpressure, round-robin order, burst lock, drops and mid-burst reset.
module tb_dom_conv_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_i;
   logic [2:0]  SSI_i;
   logic [3:0]  s_i;
   logic        wt_i;
   logic [15:0] data_i;
   logic        valid_o;
   logic        ready_o;
   logic [2:0]  SSI_o;
   logic [3:0]  s_o;
   logic        wt_o;
   logic [15:0] data_o;
   logic [3:0]  FDSTI_o_all;
   logic [3:0]  FDSSI_o;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;

   dom_conv_mc #(
      .NUM_CH(4), .SSI_WIDTH(3), .SAM_OFFSET(4), .DATA_WIDTH(16), .DEPTH(8), .MODE(0)
   ) dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_i), .ready_i(ready_i), .SSI_i(SSI_i), .s_i(s_i), .wt_i(wt_i), .data_i(data_i),
      .valid_o(valid_o), .ready_o(ready_o), .SSI_o(SSI_o), .s_o(s_o), .wt_o(wt_o), .data_o(data_o),
      .FDSTI_o_all(FDSTI_o_all), .FDSSI_o(FDSSI_o), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [2:0]  ssi;
      logic [3:0]  s;
      logic        wt;
      logic [15:0] data;
      logic        rdyO;
      logic        expRdyI;
      logic        expVo;
      logic [2:0]  expSsi;
      logic [3:0]  expS;
      logic        expWt;
      logic [15:0] expData;
      logic [3:0]  expNe;
      logic [3:0]  expFull;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mkVec(logic vld, logic [2:0] ssi, logic [3:0] s, logic wt,
                                  logic [15:0] data, logic rdyO, logic expRdyI, logic expVo,
                                  logic [2:0] expSsi, logic [3:0] expS, logic expWt,
                                  logic [15:0] expData, logic [3:0] expNe, logic [3:0] expFull);
      vec_t v;
      v.vld = vld; v.ssi = ssi; v.s = s; v.wt = wt; v.data = data; v.rdyO = rdyO;
      v.expRdyI = expRdyI; v.expVo = expVo; v.expSsi = expSsi; v.expS = expS;
      v.expWt = expWt; v.expData = expData; v.expNe = expNe; v.expFull = expFull;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushBeat(input logic [2:0] ssi, input logic [3:0] s, input logic w,
                           input logic [15:0] d);
      valid_i = 1'b1; SSI_i = ssi; s_i = s; wt_i = w; data_i = d;
      step();
      valid_i = 1'b0;
   endtask

   task automatic expectBeat(input string name, input logic [2:0] ssi, input logic [3:0] s,
                             input logic w, input logic [15:0] d);
      checkOutput(name, {7'd0, valid_o, SSI_o, s_o, wt_o, data_o}, {7'd0, 1'b1, ssi, s, w, d});
   endtask

   task automatic expectIdle(input string name);
      checkOutput(name, {31'd0, valid_o}, 32'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      valid_i = v.vld; SSI_i = v.ssi; s_i = v.s; wt_i = v.wt; data_i = v.data; ready_o = v.rdyO;
      #1;
      checkOutput($sformatf("vec%0d ready_i", idx), {31'd0, ready_i}, {31'd0, v.expRdyI});
      step();
      if (v.expVo) begin
         expectBeat($sformatf("vec%0d beat", idx), v.expSsi, v.expS, v.expWt, v.expData);
      end else begin
         expectIdle($sformatf("vec%0d idle", idx));
      end
      checkOutput($sformatf("vec%0d FDSSI_o", idx), {28'd0, FDSSI_o}, {28'd0, v.expNe});
      checkOutput($sformatf("vec%0d FDSTI_o_all", idx), {28'd0, FDSTI_o_all}, {28'd0, v.expFull});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic rdyAllOnes;
      logic outQuiet;

      rst = 1'b1; valid_i = 1'b0; SSI_i = '0; s_i = '0; wt_i = 1'b0; data_i = '0; ready_o = 1'b0;
      step();
      step();
      rst = 1'b0;

      checkOutput("reset outputs", {7'd0, valid_o, SSI_o, s_o, wt_o, data_o}, 32'd0);
      checkOutput("reset flags", {24'd0, FDSTI_o_all, FDSSI_o}, 32'd0);
      checkOutput("reset err_cnt", {24'd0, err_cnt}, 32'd0);
      #1;
      checkOutput("reset ready_i", {31'd0, ready_i}, 32'd1);

      //              vld ssi s  wt data     rdyO rdyI vo ssi s  wt data     ne       full
      vecs[0] = mkVec(1, 2, 3, 1, 16'hA5A5, 1, 1, 0, 0, 0, 0, 16'h0000, 4'b0100, 4'b0000);
      vecs[1] = mkVec(0, 0, 0, 0, 16'h0000, 1, 1, 1, 2, 3, 1, 16'hA5A5, 4'b0000, 4'b0000);
      vecs[2] = mkVec(0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000);
      vecs[3] = mkVec(1, 1, 7, 1, 16'h1234, 0, 1, 0, 0, 0, 0, 16'h0000, 4'b0010, 4'b0000);
      vecs[4] = mkVec(1, 3, 2, 1, 16'hBEEF, 0, 1, 1, 1, 7, 1, 16'h1234, 4'b1000, 4'b0000);
      vecs[5] = mkVec(0, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 7, 1, 16'h1234, 4'b1000, 4'b0000);
      vecs[6] = mkVec(0, 0, 0, 0, 16'h0000, 1, 1, 1, 3, 2, 1, 16'hBEEF, 4'b0000, 4'b0000);
      vecs[7] = mkVec(0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000);
      #1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], i);
      end
      valid_i = 1'b0;

      // Hold a ch3 beat in the output register so ch0's FIFO can fill completely.
      ready_o = 1'b0;
      pushBeat(3'd3, 4'h5, 1'b1, 16'h3333);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            checkOutput("ch0 not full at 7", {28'd0, FDSTI_o_all}, 32'd0);
         end
         pushBeat(3'd0, 4'(i), 1'b1, 16'(16'h0100 + i));
      end
      checkOutput("ch0 full", {28'd0, FDSTI_o_all}, 32'h1);
      expectBeat("ch3 held", 3'd3, 4'h5, 1'b1, 16'h3333);
      SSI_i = 3'd1;
      #1;
      checkOutput("ready_i ch1 while ch0 full", {31'd0, ready_i}, 32'd1);
      valid_i = 1'b1; SSI_i = 3'd0; s_i = 4'hF; wt_i = 1'b1; data_i = 16'h01FF;
      #1;
      checkOutput("ready_i ch0 full", {31'd0, ready_i}, 32'd0);
      step();
      valid_i = 1'b0;
      checkOutput("ch0 still full", {24'd0, FDSTI_o_all, FDSSI_o}, 32'h11);
      ready_o = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         expectBeat($sformatf("ch0 drain %0d", i), 3'd0, 4'(i), 1'b1, 16'(16'h0100 + i));
      end
      step();
      expectIdle("ch0 drained");
      checkOutput("flags after drain", {24'd0, FDSTI_o_all, FDSSI_o}, 32'd0);

      // Round-robin order: pointer, not arrival order, decides.
      doReset();
      ready_o = 1'b0;
      pushBeat(3'd0, 4'd0, 1'b1, 16'h00A0);
      pushBeat(3'd3, 4'd3, 1'b1, 16'h03A0);
      pushBeat(3'd2, 4'd2, 1'b1, 16'h02A0);
      pushBeat(3'd1, 4'd1, 1'b1, 16'h01A0);
      expectBeat("rr first ch0", 3'd0, 4'd0, 1'b1, 16'h00A0);
      checkOutput("rr queued", {28'd0, FDSSI_o}, 32'hE);
      ready_o = 1'b1;
      step();
      expectBeat("rr ch1", 3'd1, 4'd1, 1'b1, 16'h01A0);
      step();
      expectBeat("rr ch2", 3'd2, 4'd2, 1'b1, 16'h02A0);
      step();
      expectBeat("rr ch3", 3'd3, 4'd3, 1'b1, 16'h03A0);
      ready_o = 1'b0;
      pushBeat(3'd3, 4'd3, 1'b1, 16'h03B0);
      pushBeat(3'd1, 4'd1, 1'b1, 16'h01B0);
      expectBeat("rr ch3 held", 3'd3, 4'd3, 1'b1, 16'h03A0);
      ready_o = 1'b1;
      step();
      expectBeat("rr2 ch1", 3'd1, 4'd1, 1'b1, 16'h01B0);
      step();
      expectBeat("rr2 ch3", 3'd3, 4'd3, 1'b1, 16'h03B0);
      step();
      expectIdle("rr2 done");

      // Burst lock: ch0 waits while ch1's burst is incomplete.
      pushBeat(3'd1, 4'd0, 1'b0, 16'h1000);
      expectIdle("lock latency");
      pushBeat(3'd1, 4'd1, 1'b0, 16'h1001);
      expectBeat("lock b0", 3'd1, 4'd0, 1'b0, 16'h1000);
      pushBeat(3'd0, 4'd0, 1'b1, 16'h0C00);
      expectBeat("lock b1", 3'd1, 4'd1, 1'b0, 16'h1001);
      for (int i = 0; i < 5; i++) begin
         step();
         expectIdle($sformatf("lock stall %0d", i));
      end
      checkOutput("lock ch0 waiting", {28'd0, FDSSI_o}, 32'h1);
      pushBeat(3'd1, 4'd2, 1'b1, 16'h1002);
      expectIdle("lock last pushed");
      step();
      expectBeat("lock b2", 3'd1, 4'd2, 1'b1, 16'h1002);
      step();
      expectBeat("lock then ch0", 3'd0, 4'd0, 1'b1, 16'h0C00);
      step();
      expectIdle("lock done");

      // Invalid slot index: always accepted, dropped, counted with saturation.
      rdyAllOnes = 1'b1;
      outQuiet   = 1'b1;
      for (int i = 0; i < 300; i++) begin
         valid_i = 1'b1; SSI_i = 3'd5; s_i = 4'(i); wt_i = 1'b1; data_i = 16'(i);
         #1;
         if (ready_i !== 1'b1) rdyAllOnes = 1'b0;
         step();
         if (valid_o !== 1'b0 || FDSSI_o !== 4'b0000) outQuiet = 1'b0;
         if (i == 9)   checkOutput("err_cnt 10", {24'd0, err_cnt}, 32'd10);
         if (i == 253) checkOutput("err_cnt 254", {24'd0, err_cnt}, 32'd254);
         if (i == 255) checkOutput("err_cnt sat", {24'd0, err_cnt}, 32'd255);
      end
      valid_i = 1'b0;
      checkOutput("err_cnt final", {24'd0, err_cnt}, 32'd255);
      checkOutput("drop ready_i", {31'd0, rdyAllOnes}, 32'd1);
      checkOutput("drop no output", {31'd0, outQuiet}, 32'd1);

      // Reset in the middle of a stalled, locked burst.
      ready_o = 1'b0;
      pushBeat(3'd2, 4'd0, 1'b0, 16'h2000);
      pushBeat(3'd2, 4'd1, 1'b0, 16'h2001);
      pushBeat(3'd2, 4'd2, 1'b1, 16'h2002);
      expectBeat("mid-burst held", 3'd2, 4'd0, 1'b0, 16'h2000);
      checkOutput("mid-burst queued", {28'd0, FDSSI_o}, 32'h4);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset outputs", {7'd0, valid_o, SSI_o, s_o, wt_o, data_o}, 32'd0);
      checkOutput("async reset flags", {16'd0, err_cnt, FDSTI_o_all, FDSSI_o}, 32'd0);
      step();
      step();
      rst = 1'b0;
      ready_o = 1'b1;
      outQuiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (valid_o !== 1'b0 || FDSSI_o !== 4'b0000) outQuiet = 1'b0;
      end
      checkOutput("no stale beat", {31'd0, outQuiet}, 32'd1);
      pushBeat(3'd1, 4'd9, 1'b1, 16'h5A5A);
      expectIdle("post-reset latency");
      step();
      expectBeat("post-reset ch1", 3'd1, 4'd9, 1'b1, 16'h5A5A);
      step();
      expectIdle("post-reset done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dom_conv_mc.md
Name: dom_conv_mc

Overview:
- Parametrised multi-channel successor of the single-stream domain converter.
- Accepts a tagged sample stream: slot index, sample offset, write-through/last flag and data.
- Buffers each slot in its own FIFO, then re-serialises the slots onto one registered valid/ready output.
- Arbitration is burst-atomic, in round-robin or fixed-priority mode.
- Sits between the slot demapper and the downstream sample formatter; one clock domain.

Parameters:
- NUM_CH, 4: number of slots/channels (2..16).
- SSI_WIDTH, 2: slot index width; must be ≥ clog2(NUM_CH).
- SAM_OFFSET, 4: sample-offset field width.
- DATA_WIDTH, 16: sample data width.
- DEPTH, 8: per-channel FIFO depth; power of two, ≥2.
- MODE, 0: 0 = round-robin arbitration, 1 = fixed priority with lowest index first.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- valid_i  in  1  input beat valid.
- ready_i  out  1  input beat accepted when valid_i && ready_i.
- SSI_i  in  SSI_WIDTH  slot index of the input beat.
- s_i  in  SAM_OFFSET  sample offset of the input beat.
- wt_i  in  1  1 = last beat of burst (write-through point).
- data_i  in  DATA_WIDTH  input sample.
- valid_o  out  1  output beat valid (registered).
- ready_o  in  1  downstream accept.
- SSI_o  out  SSI_WIDTH  slot index of the output beat.
- s_o  out  SAM_OFFSET  sample offset of the output beat.
- wt_o  out  1  last-of-burst flag of the output beat.
- data_o  out  DATA_WIDTH  output sample.
- FDSTI_o_all  out  NUM_CH  per-channel FIFO full flags.
- FDSSI_o  out  NUM_CH  per-channel FIFO non-empty flags.
- err_cnt  out  8  saturating count of dropped beats.

Behaviour:
- Reset (async, active-high):
  - all FIFOs empty; valid_o = 0; SSI_o, s_o, wt_o, data_o = 0.
  - FDSTI_o_all = 0; FDSSI_o = 0; err_cnt = 0.
  - round-robin pointer = 0; burst lock cleared.
  - Reset mid-burst discards all buffered and in-flight beats; no partial burst is emitted afterwards.
- Input:
  - ready_i = !full[SSI_i], combinational on SSI_i.
  - If SSI_i ≥ NUM_CH: ready_i = 1 and the beat is dropped. err_cnt increments, saturating at 255.
  - An accepted beat writes {wt_i, s_i, data_i} into FIFO[SSI_i] at the clock edge.
- FIFOs:
  - Pointers are clog2(DEPTH)+1 bits wide; full/empty decoded from pointer MSB and equality.
  - Push to a full FIFO is impossible (ready_i = 0). Pop from an empty FIFO never occurs.
  - A simultaneous push and pop on the same channel is legal; the occupancy count is unchanged.
  - FDSTI_o_all and FDSSI_o are registered-pointer decodes, valid in the cycle after the change.
- Output stage (single register):
  - load = (!valid_o || ready_o) && a channel is granted.
  - On load: the FIFO head of the granted channel pops; the output fields are updated; valid_o = 1.
  - If (valid_o && ready_o && no grant): valid_o → 0.
  - While valid_o && !ready_o: all outputs hold stable.
- Arbitration states:
  - IDLE/unlocked: grant the requesting channel selected by MODE.
    - MODE 0: first non-empty channel at or after rr_ptr, wrapping modulo NUM_CH.
    - MODE 1: lowest-index non-empty channel.
  - On a grant with wt = 0: enter LOCKED(ch).
  - LOCKED(ch): only ch may be granted. If FIFO[ch] is empty the output stalls; no other channel is served.
  - A grant with wt = 1 returns to unlocked. In MODE 0, rr_ptr = (ch+1) mod NUM_CH.
  - A single-beat burst (wt = 1) never locks.
- Latency: a beat accepted at edge N can appear on valid_o from the cycle after edge N+1 at the earliest (2 cycles).
- Throughput: 1 beat/cycle when ready_o is held high and the selected FIFO stays non-empty.
- Ordering: order is preserved within a channel; no beat is duplicated or lost except invalid-SSI drops.

Test Plan:
- Reset, then push ch2 {s=3, wt=1, data=0xA5A5} → valid_o rises 2 cycles later with SSI_o=2, s_o=3, wt_o=1, data_o=0xA5A5. FDSSI_o[2] is 1 then 0 after the pop.
- Fill ch0 with 8 beats while ready_o = 0 → FDSTI_o_all[0] = 1 and ready_i = 0 for SSI_i=0. ready_i stays 1 for SSI_i=1. The 9th beat is not accepted.
- MODE 0, with one wt=1 beat each queued in ch0..ch3 and ready_o = 1 → output SSI order 0,1,2,3. Requeue ch1 and ch3 → order 1,3 (pointer continues from 0→1).
- Burst lock: ch1 holds 3 beats (wt 0,0,1) with the last one delayed 5 cycles; ch0 has data waiting → ch1 beats emit, the output stalls 5 cycles, ch1's last beat emits, then ch0 is served. No interleaving.
- Input SSI_i=5 with NUM_CH=4, 300 beats → all accepted, no output produced, err_cnt saturates at 255.
- Assert rst while valid_o=1, ready_o=0, mid-burst → valid_o = 0 immediately. After release, FDSSI_o = 0 and no stale beat appears on the output.
